// File: rtl/select_shift_pipe_if.sv
// Operand/result handshake bundle for select_shift_pipe.
// master drives operands and out_ready; slave is the pipeline itself.
interface select_shift_pipe_if #(
    parameter int unsigned DATAW = 64,
    parameter int unsigned OUTW  = 32,
    parameter int unsigned SHW   = 6
);
    logic [DATAW-1:0] a;
    logic [DATAW-1:0] b;
    logic [DATAW-1:0] c;
    logic [SHW-1:0]   sh;
    logic             in_valid;
    logic             in_ready;
    logic [OUTW-1:0]  x;
    logic [OUTW-1:0]  z;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      xfer_cnt;

    modport master (
        output a, b, c, sh, in_valid, out_ready,
        input  in_ready, x, z, out_valid, xfer_cnt
    );

    modport slave (
        input  a, b, c, sh, in_valid, out_ready,
        output in_ready, x, z, out_valid, xfer_cnt
    );
endinterface

// File: rtl/select_shift_pipe.sv
// Two-stage select-then-shift pipeline with valid/ready flow control on both sides
// and a wrapping count of delivered results.
module select_shift_pipe #(
    parameter int unsigned DATAW = 64,
    parameter int unsigned OUTW  = 32,
    parameter int unsigned SHW   = 6
) (
    input logic                Clk,
    input logic                Rst,
    select_shift_pipe_if.slave io
);

    // Stage-1 combinational compare/select
    logic [DATAW-1:0] d_sum;
    logic [DATAW-1:0] e_sum;
    logic [DATAW-1:0] f_diff;
    logic             d_lt_e;
    logic             d_eq_e;
    logic [DATAW-1:0] g_sel;
    logic [DATAW-1:0] h_sel;

    // Stage-1 register
    logic             s1_valid_q, s1_valid_d;
    logic [DATAW-1:0] s1_g_q, s1_g_d;
    logic [DATAW-1:0] s1_h_q, s1_h_d;
    logic             s1_lt_q, s1_lt_d;
    logic             s1_eq_q, s1_eq_d;
    logic [SHW-1:0]   s1_sh_q, s1_sh_d;

    // Output register
    logic             out_valid_q, out_valid_d;
    logic [OUTW-1:0]  x_q, x_d;
    logic [OUTW-1:0]  z_q, z_d;
    logic [15:0]      xfer_cnt_q, xfer_cnt_d;

    // Stage-2 combinational shift
    logic [SHW-1:0]   sh_x;
    logic [SHW-1:0]   sh_z;
    logic [DATAW-1:0] x_full;
    logic [DATAW-1:0] z_full;

    logic             adv2;
    logic             in_ready;
    logic             in_xfer;
    logic             out_xfer;

    // Ready is a function of registered valids and out_ready only, never in_valid.
    always_comb begin
        adv2     = !out_valid_q || io.out_ready;
        in_ready = !s1_valid_q || adv2;
        in_xfer  = io.in_valid && in_ready;
        out_xfer = out_valid_q && io.out_ready;
    end

    always_comb begin
        d_sum  = io.a + io.b;
        e_sum  = io.a + io.c;
        f_diff = io.a - io.b;
        d_lt_e = d_sum < e_sum;
        d_eq_e = d_sum == e_sum;
        g_sel  = d_lt_e ? d_sum : e_sum;
        h_sel  = d_eq_e ? g_sel : f_diff;
    end

    // Shifts run at full datapath width so bits shifted in from above OUTW are kept.
    always_comb begin
        sh_x   = s1_lt_q ? s1_sh_q : '0;
        sh_z   = s1_eq_q ? s1_sh_q : '0;
        x_full = s1_h_q << sh_x;
        z_full = s1_g_q >> sh_z;
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_g_d     = s1_g_q;
        s1_h_d     = s1_h_q;
        s1_lt_d    = s1_lt_q;
        s1_eq_d    = s1_eq_q;
        s1_sh_d    = s1_sh_q;
        if (in_ready) begin
            s1_valid_d = io.in_valid;
        end
        if (in_xfer) begin
            s1_g_d  = g_sel;
            s1_h_d  = h_sel;
            s1_lt_d = d_lt_e;
            s1_eq_d = d_eq_e;
            s1_sh_d = io.sh;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        x_d         = x_q;
        z_d         = z_q;
        if (adv2) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                x_d = x_full[OUTW-1:0];
                z_d = z_full[OUTW-1:0];
            end
        end
    end

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (out_xfer) begin
            xfer_cnt_d = xfer_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            s1_valid_q  <= 1'b0;
            s1_g_q      <= '0;
            s1_h_q      <= '0;
            s1_lt_q     <= 1'b0;
            s1_eq_q     <= 1'b0;
            s1_sh_q     <= '0;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            z_q         <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_g_q      <= s1_g_d;
            s1_h_q      <= s1_h_d;
            s1_lt_q     <= s1_lt_d;
            s1_eq_q     <= s1_eq_d;
            s1_sh_q     <= s1_sh_d;
            out_valid_q <= out_valid_d;
            x_q         <= x_d;
            z_q         <= z_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign io.in_ready  = in_ready;
    assign io.out_valid = out_valid_q;
    assign io.x         = x_q;
    assign io.z         = z_q;
    assign io.xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_select_shift_pipe.sv
// Directed bench for select_shift_pipe: a reference model feeds a scoreboard queue on
// each accepted input, and every delivered result is popped and compared.
module tb_select_shift_pipe;

    logic clk;
    logic rst;

    select_shift_pipe_if #(.DATAW(64), .OUTW(32), .SHW(6)) ifc ();

    select_shift_pipe #(.DATAW(64), .OUTW(32), .SHW(6)) dut (
        .Clk (clk),
        .Rst (rst),
        .io  (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec;
    int          n_fail;
    logic [63:0] sb[$];
    logic        acc;
    logic        blocked;
    logic        stalled;
    logic [31:0] hold_x;
    logic [31:0] hold_z;
    logic [15:0] exp_cnt;
    int          sent;

    function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic [63:0] c, input logic [5:0] sh);
        logic [63:0] d, e, f, g, h, xs, zs;
        logic        lt, eq;
        d  = a + b;
        e  = a + c;
        f  = a - b;
        lt = d < e;
        eq = d == e;
        g  = lt ? d : e;
        h  = eq ? g : f;
        xs = h << (lt ? sh : 6'd0);
        zs = g >> (eq ? sh : 6'd0);
        return {xs[31:0], zs[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at the falling edge, then advance past the rising edge.
    task automatic cyc();
        logic [63:0] e;
        acc = 1'b0;
        @(negedge clk);
        if (rst) begin
            sb.delete();
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", 64'(ifc.out_valid), 64'd1);
                chk("hold_x", 64'(ifc.x), 64'(hold_x));
                chk("hold_z", 64'(ifc.z), 64'(hold_z));
            end
            if (ifc.in_valid && !ifc.in_ready) blocked = 1'b1;
            if (ifc.in_valid && ifc.in_ready) begin
                sb.push_back(model(ifc.a, ifc.b, ifc.c, ifc.sh));
                acc = 1'b1;
            end
            if (ifc.out_valid && ifc.out_ready) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 64'(ifc.out_valid), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("x", 64'(ifc.x), 64'(e[63:32]));
                    chk("z", 64'(ifc.z), 64'(e[31:0]));
                end
                exp_cnt++;
            end
            stalled = ifc.out_valid && !ifc.out_ready;
            hold_x  = ifc.x;
            hold_z  = ifc.z;
        end
        @(posedge clk);
        #1;
        if (rst) exp_cnt = '0;
    endtask

    task automatic set_in(input logic v, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] c, input logic [5:0] sh);
        ifc.in_valid = v;
        ifc.a        = a;
        ifc.b        = b;
        ifc.c        = c;
        ifc.sh       = sh;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        n_vec   = 0;
        n_fail  = 0;
        acc     = 1'b0;
        blocked = 1'b0;
        stalled = 1'b0;
        hold_x  = '0;
        hold_z  = '0;
        exp_cnt = '0;
        rst     = 1'b1;
        ifc.out_ready = 1'b1;
        set_in(1'b0, 64'd0, 64'd0, 64'd0, 6'd0);
        @(posedge clk);
        #1;

        // Reset state
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        chk("rst_x", 64'(ifc.x), 64'd0);
        chk("rst_z", 64'(ifc.z), 64'd0);
        chk("rst_cnt", 64'(ifc.xfer_cnt), 64'd0);
        chk("rst_in_ready", 64'(ifc.in_ready), 64'd1);

        // Basic case and two-cycle latency
        set_in(1'b1, 64'd5, 64'd3, 64'd10, 6'd1);
        cyc();
        chk("basic_acc", 64'(acc), 64'd1);
        set_in(1'b0, 64'd0, 64'd0, 64'd0, 6'd0);
        chk("lat_ov_early", 64'(ifc.out_valid), 64'd0);
        cyc();
        chk("lat_ov", 64'(ifc.out_valid), 64'd1);
        chk("basic_x", 64'(ifc.x), 64'd4);
        chk("basic_z", 64'(ifc.z), 64'd8);
        cyc();

        // Equality and wrap cases back to back
        set_in(1'b1, 64'd1, 64'd4, 64'd4, 6'd2);
        cyc();
        set_in(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 6'd3);
        cyc();
        set_in(1'b0, 64'd0, 64'd0, 64'd0, 6'd0);
        chk("eq_x", 64'(ifc.x), 64'd5);
        chk("eq_z", 64'(ifc.z), 64'd1);
        cyc();
        chk("wrap_x", 64'(ifc.x), 64'hFFFF_FFF0);
        chk("wrap_z", 64'(ifc.z), 64'd0);
        cyc();
        cyc();
        chk("sb_drain1", 64'(sb.size()), 64'd0);

        // Random traffic with random backpressure
        for (int i = 0; i < 60; i++) begin
            set_in(1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom},
                   (i % 5 == 0) ? 64'd0 : {$urandom, $urandom}, 6'($urandom));
            if (i % 7 == 3) ifc.c = ifc.b;
            ifc.out_ready = ($urandom_range(0, 9) < 7);
            cyc();
        end
        set_in(1'b0, 64'd0, 64'd0, 64'd0, 6'd0);
        ifc.out_ready = 1'b1;
        repeat (4) cyc();
        chk("sb_drain2", 64'(sb.size()), 64'd0);

        // Backpressure: five sets, out_ready low on cycles 3-6
        do_reset();
        sent    = 0;
        blocked = 1'b0;
        for (int i = 1; i <= 14; i++) begin
            ifc.out_ready = !(i >= 3 && i <= 6);
            set_in(sent < 5, 64'(100 + sent), 64'(7 * sent), 64'(3 + sent * sent),
                   6'(sent + 1));
            cyc();
            if (acc) sent++;
        end
        set_in(1'b0, 64'd0, 64'd0, 64'd0, 6'd0);
        ifc.out_ready = 1'b1;
        chk("bp_blocked", 64'(blocked), 64'd1);
        chk("bp_sent", 64'(sent), 64'd5);
        chk("bp_cnt", 64'(ifc.xfer_cnt), 64'd5);
        chk("bp_sb_empty", 64'(sb.size()), 64'd0);

        // Reset while both stages hold data
        ifc.out_ready = 1'b0;
        set_in(1'b1, 64'd20, 64'd2, 64'd30, 6'd4);
        cyc();
        set_in(1'b1, 64'd40, 64'd9, 64'd9, 6'd5);
        cyc();
        set_in(1'b0, 64'd0, 64'd0, 64'd0, 6'd0);
        chk("pre_rst_ov", 64'(ifc.out_valid), 64'd1);
        chk("pre_rst_ir", 64'(ifc.in_ready), 64'd0);
        rst = 1'b1;
        ifc.out_ready = 1'b1;
        cyc();
        rst = 1'b0;
        ifc.out_ready = 1'b0;
        chk("mid_rst_ov", 64'(ifc.out_valid), 64'd0);
        chk("mid_rst_x", 64'(ifc.x), 64'd0);
        chk("mid_rst_z", 64'(ifc.z), 64'd0);
        chk("mid_rst_cnt", 64'(ifc.xfer_cnt), 64'd0);
        chk("mid_rst_ir", 64'(ifc.in_ready), 64'd1);
        ifc.out_ready = 1'b1;
        repeat (4) cyc();
        chk("no_stale", 64'(ifc.out_valid), 64'd0);
        chk("no_stale_cnt", 64'(ifc.xfer_cnt), 64'd0);

        // Counter wrap: 65537 transfers at full throughput
        do_reset();
        sent = 0;
        while (sent < 65537) begin
            set_in(1'b1, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                   6'($urandom));
            cyc();
            if (acc) sent++;
        end
        set_in(1'b0, 64'd0, 64'd0, 64'd0, 6'd0);
        repeat (3) cyc();
        chk("wrap_cnt", 64'(ifc.xfer_cnt), 64'd1);
        chk("wrap_cnt_model", 64'(ifc.xfer_cnt), 64'(exp_cnt));
        chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
